divider_vv: RTL and testbench
=============================

DIVIDER_VV -- requirements
Module: divider_vv

Interface
REQ-001 SHALL have parameter vector, default 4: number of independent lanes.
REQ-002 SHALL have parameter bus, default 4: lane width in bits, unsigned operands.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a vector division, sampled on clk.
REQ-006 SHALL have port a  input  [vector-1:0][bus-1:0]  per-lane dividend.
REQ-007 SHALL have port b  input  [vector-1:0][bus-1:0]  per-lane divisor.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port quotient  output  [vector-1:0][bus-1:0]  per-lane quotient.
REQ-011 SHALL have port remainder  output  [vector-1:0][bus-1:0]  per-lane remainder.
REQ-012 SHALL have port div_zero  output  [vector-1:0]  per-lane divide-by-zero flag, same lane order as a/b.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-014 In IDLE or DONE, start=1 at a clock edge SHALL capture a and b into internal registers, clear the per-lane partial remainders, load the step counter with bus-1, and enter RUN.
REQ-015 In IDLE, start=0 SHALL hold IDLE. In DONE, start=0 SHALL return to IDLE.
REQ-016 In RUN, each cycle SHALL perform one restoring-division step on every lane in parallel, MSB of the dividend first:
- shift the partial remainder left by one, bringing in the next dividend bit
- if the result is >= the divisor, subtract and set the quotient bit to 1; otherwise keep it and set the bit to 0.
REQ-017 The comparison/subtraction SHALL use bus+1 bits so no step overflows.
REQ-018 RUN SHALL last exactly bus cycles. When the counter reaches 0, the step result SHALL be written to quotient, remainder and div_zero, and the FSM SHALL enter DONE.
REQ-019 Latency: if start is sampled at edge N, done SHALL be high during the cycle following edge N+bus.
REQ-020 done SHALL be high only in DONE and only for one cycle per operation.
REQ-021 busy SHALL be high exactly in RUN.
REQ-022 start while in RUN SHALL be ignored: no operand capture and no effect on the operation in progress.
REQ-023 start in DONE SHALL begin a new operation back-to-back, with done still pulsing for the finished one.
REQ-024 Lane with b=0 SHALL produce quotient all ones, remainder equal to its dividend, and div_zero=1. The natural restoring algorithm yields this result and SHALL NOT be special-cased in timing.
REQ-025 Lane with b!=0 SHALL produce div_zero=0, quotient=floor(a/b) and remainder=a mod b.
REQ-026 quotient, remainder and div_zero SHALL be registered and SHALL change only at the RUN-to-DONE transition. They SHALL hold their value until the next completion.
REQ-027 Operand changes on a/b after capture SHALL NOT affect the operation in progress.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for clk, force:
- FSM to IDLE
- busy=0 and done=0
- quotient, remainder and div_zero to all zeros
- internal operand, partial-remainder and counter registers to zero.
REQ-029 reset asserted mid-RUN SHALL abort the operation, produce no done pulse, and leave outputs at their reset values.
REQ-030 After reset deasserts, the first start SHALL be accepted at the next rising edge.

Verification (vector=4, bus=4)
REQ-031 Basic operation:
- stimulus: a={13,15,7,0}, b={3,1,2,5}, start pulse
- response: busy for 4 cycles, then done, quotient={4,15,3,0}, remainder={1,0,1,0}, div_zero=0000.
REQ-032 Divide by zero:
- stimulus: a={9,0,15,4}, b={0,0,0,4}
- response: quotient={15,15,15,1}, remainder={9,0,15,0}, div_zero=1110 in a,b lane order (lanes 3,2,1 set; lane 0 clear).
REQ-033 Start while busy:
- stimulus: second start pulse with different operands, issued while busy=1
- response: it is ignored; the result matches the first operands and exactly one done pulse occurs.
REQ-034 Back-to-back:
- stimulus: start held high continuously
- response: done every 5 cycles (bus+1); each result matches the operands captured at the start of that operation.
REQ-035 Reset mid-operation:
- stimulus: reset=0 asserted two cycles into RUN
- response: busy=0 and outputs zero immediately, no done pulse follows; the next start produces a correct result.
REQ-036 Exhaustive check:
- stimulus: all 256 a/b pairs, applied identically on all lanes
- response: every result is checked against integer division and modulo, with the REQ-024 rule applied when b=0.

Source files
------------

// File: rtl/divider_vv.sv
// Multi-lane unsigned restoring divider: every lane divides in parallel,
// one quotient bit per clock, MSB first; results are held until the next completion.
module divider_vv #(
  parameter int vector = 4,
  parameter int bus    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [vector-1:0][bus-1:0]  a,
  input  logic [vector-1:0][bus-1:0]  b,
  output logic                        busy,
  output logic                        done,
  output logic [vector-1:0][bus-1:0]  quotient,
  output logic [vector-1:0][bus-1:0]  remainder,
  output logic [vector-1:0]           div_zero
);

  localparam int CW = (bus > 1) ? $clog2(bus) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [vector-1:0][bus-1:0]   a_q, b_q, rem_q;
  logic [vector-1:0][bus-1:0]   a_d, rem_d;
  logic [vector-1:0][bus-1:0]   quotient_q, remainder_q;
  logic [vector-1:0]            div_zero_q, zero_d;
  logic [CW-1:0]                cnt_q;
  logic                         load, step, last;

  assign load = start && (state_q != RUN);
  assign step = (state_q == RUN);
  assign last = step && (cnt_q == '0);

  // The dividend register doubles as the quotient register: its MSB feeds the
  // partial remainder and the new quotient bit enters at the LSB.
  for (genvar gi = 0; gi < vector; gi++) begin : g_lane
    logic [bus:0]   shifted;
    logic [bus-1:0] diff;
    logic           ge;

    assign shifted    = {rem_q[gi], a_q[gi][bus-1]};
    assign ge         = shifted >= {1'b0, b_q[gi]};
    // When ge holds the true difference is below the divisor, so the low bits suffice.
    assign diff       = shifted[bus-1:0] - b_q[gi];
    assign rem_d[gi]  = ge ? diff : shifted[bus-1:0];
    assign a_d[gi]    = {a_q[gi][bus-2:0], ge};
    assign zero_d[gi] = (b_q[gi] == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        rem_q <= '0;
        cnt_q <= CW'(bus - 1);
      end else if (step) begin
        a_q   <= a_d;
        rem_q <= rem_d;
        cnt_q <= cnt_q - CW'(1);
      end
      if (last) begin
        quotient_q  <= a_d;
        remainder_q <= rem_d;
        div_zero_q  <= zero_d;
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_divider_vv.sv
// Scoreboard bench for divider_vv: expected results are queued at stimulus
// time and compared by a monitor whenever done is seen.
module tb_divider_vv;
  localparam int V = 4;
  localparam int W = 4;

  typedef logic [V-1:0][W-1:0] vec_t;
  typedef struct {
    vec_t           q;
    vec_t           r;
    logic [V-1:0]   dz;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  vec_t           a = '0;
  vec_t           b = '0;
  logic           busy, done;
  vec_t           quotient, remainder;
  logic [V-1:0]   div_zero;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  divider_vv #(.vector(V), .bus(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input vec_t av, input vec_t bv);
    exp_t e;
    for (int j = 0; j < V; j++) begin
      if (bv[j] == '0) begin
        e.q[j]  = '1;
        e.r[j]  = av[j];
        e.dz[j] = 1'b1;
      end else begin
        e.q[j]  = av[j] / bv[j];
        e.r[j]  = av[j] % bv[j];
        e.dz[j] = 1'b0;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check_eq("quotient", 64'(quotient), 64'(e.q));
        check_eq("remainder", 64'(remainder), 64'(e.r));
        check_eq("div_zero", 64'(div_zero), 64'(e.dz));
        $display("txn done q=%h r=%h dz=%b", quotient, remainder, div_zero);
      end
    end
  end

  // Called on the negedge right after the accepting edge; measures cycles to done.
  task automatic wait_done(input string tag);
    int k = 0;
    int bsy = 0;
    while (!done && k < W + 6) begin
      bsy += int'(busy);
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_latency"}, 64'(k), 64'(W));
    check_eq({tag, "_busy_cycles"}, 64'(bsy), 64'(W));
  endtask

  task automatic do_op(input string tag, input vec_t av, input vec_t bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    sb.push_back(model(av, bv));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = vec_t'($urandom);
    b = vec_t'($urandom);
    wait_done(tag);
    @(negedge clk);
    check_eq({tag, "_done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dc0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_quotient", 64'(quotient), 64'd0);
    check_eq("rst_remainder", 64'(remainder), 64'd0);
    check_eq("rst_div_zero", 64'(div_zero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_op("basic", {4'd13, 4'd15, 4'd7, 4'd0}, {4'd3, 4'd1, 4'd2, 4'd5});
    check_eq("basic_q_lit", 64'(quotient), 64'h4F30);
    check_eq("basic_r_lit", 64'(remainder), 64'h1010);

    do_op("divzero", {4'd9, 4'd0, 4'd15, 4'd4}, {4'd0, 4'd0, 4'd0, 4'd4});
    check_eq("divzero_q_lit", 64'(quotient), 64'hFFF1);
    check_eq("divzero_r_lit", 64'(remainder), 64'h90F0);
    check_eq("divzero_dz_lit", 64'(div_zero), 64'b1110);

    // Start while busy: the second request must be ignored.
    @(negedge clk);
    a = {4'd14, 4'd9, 4'd8, 4'd11};
    b = {4'd4, 4'd2, 4'd3, 4'd7};
    start = 1'b1;
    sb.push_back(model(a, b));
    dc0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = {4'd1, 4'd2, 4'd3, 4'd4};
    b = {4'd1, 4'd1, 4'd1, 4'd1};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < W + 6 && !done; k++) @(negedge clk);
    repeat (W + 3) @(negedge clk);
    check_eq("busy_start_dones", 64'(done_cnt - dc0), 64'd1);

    // Back-to-back with start held high; operands scrambled between captures.
    @(negedge clk);
    a = {4'd15, 4'd6, 4'd10, 4'd3};
    b = {4'd2, 4'd6, 4'd0, 4'd5};
    start = 1'b1;
    sb.push_back(model(a, b));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      for (int k = 0; k <= W; k++) begin
        @(negedge clk);
        if (k < W) begin
          check_eq("b2b_no_early_done", 64'(done), 64'd0);
          a = vec_t'($urandom);
          b = vec_t'($urandom);
        end else begin
          check_eq("b2b_done", 64'(done), 64'd1);
          if (i < 3) begin
            a = vec_t'($urandom);
            b = vec_t'($urandom);
            sb.push_back(model(a, b));
          end else begin
            start = 1'b0;
          end
        end
      end
    end
    repeat (2) @(negedge clk);

    // Reset two cycles into RUN: abort with no done pulse.
    a = {4'd12, 4'd7, 4'd5, 4'd9};
    b = {4'd5, 4'd2, 4'd1, 4'd3};
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dc0 = done_cnt;
    reset = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_quotient", 64'(quotient), 64'd0);
    check_eq("abort_remainder", 64'(remainder), 64'd0);
    check_eq("abort_div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (W + 3) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt - dc0), 64'd0);
    do_op("post_reset", {4'd12, 4'd7, 4'd5, 4'd9}, {4'd5, 4'd2, 4'd1, 4'd3});

    // Exhaustive, identical operands on every lane.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        vec_t av, bv;
        for (int j = 0; j < V; j++) begin
          av[j] = W'(x);
          bv[j] = W'(y);
        end
        do_op("exh", av, bv);
      end
    end

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
